// File: rtl/ps2_tx.sv
// PS/2 host transmitter: sends one command byte to a PS/2 device.
// The host inhibits the clock line, asserts request-to-send with the start
// bit, releases the clock and shifts data/parity/stop on device-generated
// falling edges, then checks the device acknowledge on the eleventh edge.
module ps2_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int RTS_CYCLES     = 10,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       rst_b,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_stall,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_out,
  output logic       ps2_dat_out,
  output logic       ce,
  output logic       de,
  output logic       tx_done,
  output logic       tx_err
);

  localparam int PH_MAX = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
  localparam int CNT_W  = $clog2(PH_MAX + 1);
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] RTS_LAST = CNT_W'(RTS_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_XFER,
    S_ACK
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_done;
  logic             r_err;
  logic             w_done_nxt;
  logic             w_err_nxt;

  logic             r_clk_s1;
  logic             r_clk_s2;
  logic             r_clk_hist;
  logic             r_dat_s1;
  logic             r_dat_s2;
  logic             w_fall;

  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_n;
  logic [TO_W-1:0]  r_to;
  logic             w_timeout;

  logic [7:0]       r_byte;
  logic             r_par;
  logic [2:0]       w_bit_idx;

  // A falling edge is history high while the synchronized clock reads low.
  assign w_fall    = r_clk_hist & ~r_clk_s2;
  // Counter reaches TIMEOUT_CYCLES on the coming clock edge.
  assign w_timeout = (r_to == TO_LAST);
  // Edge n (1..8) selects data bit n-1.
  assign w_bit_idx = r_n[2:0] - 3'd1;

  // Synchronize the PS/2 lines; idle-high reset value avoids a false edge.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_clk_hist <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
    end else begin
      r_clk_s1   <= ps2_clk;
      r_clk_s2   <= r_clk_s1;
      r_clk_hist <= r_clk_s2;
      r_dat_s1   <= ps2_data;
      r_dat_s2   <= r_dat_s1;
    end
  end

  // State register with registered completion pulses, landing in the first IDLE cycle.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Next-state logic; in ACK the device edge takes priority over the timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (tx_valid) w_state_nxt = S_INHIBIT;
      end
      S_INHIBIT: begin
        if (r_cnt == INH_LAST) w_state_nxt = S_RTS;
      end
      S_RTS: begin
        if (r_cnt == RTS_LAST) w_state_nxt = S_XFER;
      end
      S_XFER: begin
        if (w_timeout) begin
          w_state_nxt = S_IDLE;
          w_err_nxt   = 1'b1;
        end else if (w_fall && (r_n == 4'd9)) begin
          w_state_nxt = S_ACK;
        end
      end
      S_ACK: begin
        if (w_fall) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = ~r_dat_s2;
          w_err_nxt   = r_dat_s2;
        end else if (w_timeout) begin
          w_state_nxt = S_IDLE;
          w_err_nxt   = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Phase, edge and timeout counters.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_cnt <= '0;
      r_n   <= '0;
      r_to  <= '0;
    end else begin
      if (r_state != w_state_nxt) begin
        r_cnt <= '0;
      end else if ((r_state == S_INHIBIT) || (r_state == S_RTS)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      if ((r_state == S_XFER) && w_fall) begin
        r_n <= r_n + 4'd1;
      end else if ((r_state != S_XFER) && (r_state != S_ACK)) begin
        r_n <= '0;
      end

      if ((r_state == S_XFER) || (r_state == S_ACK)) begin
        r_to <= r_to + TO_W'(1);
      end else begin
        r_to <= '0;
      end
    end
  end

  // Capture the command byte and its odd-parity bit when it is accepted.
  always_ff @(posedge clk) begin
    if ((r_state == S_IDLE) && tx_valid) begin
      r_byte <= tx_data;
      r_par  <= ~^tx_data;
    end
  end

  // Line drive per state; lines idle released and high.
  always_comb begin
    ce          = 1'b0;
    de          = 1'b0;
    ps2_clk_out = 1'b1;
    ps2_dat_out = 1'b1;
    tx_stall    = (r_state != S_IDLE);
    tx_done     = r_done;
    tx_err      = r_err;
    case (r_state)
      S_INHIBIT: begin
        ce          = 1'b1;
        ps2_clk_out = 1'b0;
      end
      S_RTS: begin
        ce          = 1'b1;
        ps2_clk_out = 1'b0;
        de          = 1'b1;
        ps2_dat_out = 1'b0;
      end
      S_XFER: begin
        de = 1'b1;
        case (r_n)
          4'd0:    ps2_dat_out = 1'b0;
          4'd9:    ps2_dat_out = r_par;
          4'd10:   de          = 1'b0;
          default: ps2_dat_out = r_byte[w_bit_idx];
        endcase
      end
      default: begin
        ce = 1'b0;
        de = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ps2_tx.sv
// Bench for ps2_tx: a PS/2 device model clocks the frame out of the host,
// a scoreboard holds the expected frame and outcome of every queued byte.
module tb_ps2_tx;

  localparam int INH  = 40;
  localparam int RTS  = 10;
  localparam int TO   = 600;
  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       rst_b;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_stall;
  logic       ps2_clk;
  logic       ps2_data;
  logic       ps2_clk_out;
  logic       ps2_dat_out;
  logic       ce;
  logic       de;
  logic       tx_done;
  logic       tx_err;
  logic       dev_clk;
  logic       dev_dat;

  ps2_tx #(
    .INHIBIT_CYCLES(INH),
    .RTS_CYCLES    (RTS),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_stall   (tx_stall),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .ps2_clk_out(ps2_clk_out),
    .ps2_dat_out(ps2_dat_out),
    .ce         (ce),
    .de         (de),
    .tx_done    (tx_done),
    .tx_err     (tx_err)
  );

  always #5 clk = ~clk;

  // Open-drain lines: device owns the clock, data is wired-AND.
  assign ps2_clk  = dev_clk;
  assign ps2_data = (de ? ps2_dat_out : 1'b1) & dev_dat;

  typedef struct {
    logic [10:0] frame;
    logic        exp_done;
    logic        exp_err;
  } sb_t;

  typedef struct {
    logic [7:0] data;
    logic       nack;
    logic       par;
    logic       exp_done;
    logic       exp_err;
  } vec_t;

  sb_t  sb_q[$];
  vec_t vecs[5];

  int checks = 0;
  int errors = 0;

  // Monitor state, updated on the falling clock edge.
  int         cyc = 0;
  int         inh_run = 0, rts_run = 0, inh_len = 0, rts_len = 0;
  int         xfer_cyc = 0, err_cyc = 0, done_cyc = 0, inh_gap = 0;
  int         done_cnt = 0, err_cnt = 0, overlap = 0;
  logic [1:0] err_lines = 2'b11;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (ce && !de) begin
      inh_run <= inh_run + 1;
      if (inh_run == 0) inh_gap <= cyc - done_cyc;
    end else begin
      if (inh_run != 0) inh_len <= inh_run;
      inh_run <= 0;
    end
    if (ce && de) begin
      rts_run <= rts_run + 1;
    end else begin
      if (rts_run != 0) rts_len <= rts_run;
      rts_run <= 0;
    end
    if (!ce && de && tx_stall && (rts_run != 0)) xfer_cyc <= cyc;
    if (tx_done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (tx_err) begin
      err_cnt   <= err_cnt + 1;
      err_cyc   <= cyc;
      err_lines <= {ce, de};
    end
    if (tx_done && tx_err) overlap <= overlap + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic p);
    return {1'b1, p, d, 1'b0};
  endfunction

  task automatic push_exp(input logic [10:0] f, input logic ed, input logic ee);
    sb_t e;
    e.frame    = f;
    e.exp_done = ed;
    e.exp_err  = ee;
    sb_q.push_back(e);
  endtask

  // Offer one byte for a single cycle, then scramble tx_data while busy.
  task automatic send(input logic [7:0] d, input logic [10:0] f, input logic ed, input logic ee);
    push_exp(f, ed, ee);
    tx_valid = 1'b1;
    tx_data  = d;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = ~d;
  endtask

  task automatic wait_xfer(output logic ok);
    int n = 0;
    ok = 1'b1;
    while (!(!ce && de && tx_stall)) begin
      @(negedge clk);
      n++;
      if (n > 3000) begin
        checks++;
        errors++;
        $display("FAIL xfer_wait: no clock release within %0d cycles", n);
        ok = 1'b0;
        return;
      end
    end
  endtask

  task automatic dev_edge(output logic smp);
    dev_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    smp = ps2_data;
    dev_clk = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  // Device model: clock out start..stop, answer ACK/NACK on edge 11, score it.
  task automatic dev_run(input logic nack);
    logic [10:0] cap;
    logic        ok;
    logic        b;
    sb_t         e;
    int          d0, e0;
    wait_xfer(ok);
    if (!ok) return;
    d0 = done_cnt;
    e0 = err_cnt;
    cap[0] = ps2_data;
    for (int i = 1; i <= 10; i++) begin
      dev_edge(b);
      cap[i] = b;
    end
    dev_dat = nack;
    repeat (2) @(negedge clk);
    dev_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    dev_clk = 1'b1;
    repeat (4) @(negedge clk);
    dev_dat = 1'b1;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: frame 0x%0h with nothing expected", cap);
    end else begin
      e = sb_q.pop_front();
      check("frame", 32'(cap), 32'(e.frame));
      check("done_pulses", done_cnt - d0, 32'(e.exp_done));
      check("err_pulses", err_cnt - e0, 32'(e.exp_err));
      check("inhibit_len", inh_len, INH);
      check("rts_len", rts_len, RTS);
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic ok;
    logic b;
    int   d0, e0, n;
    sb_t  junk;

    vecs[0] = '{8'hF4, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{8'hFF, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{8'h01, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{8'hA5, 1'b1, 1'b1, 1'b0, 1'b1};

    rst_b    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    dev_clk  = 1'b1;
    dev_dat  = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", {25'd0, ce, de, ps2_clk_out, ps2_dat_out, tx_stall, tx_done, tx_err},
          32'b0011000);
    rst_b = 1'b1;
    @(negedge clk);

    // Table-driven single transfers.
    for (int i = 0; i < 5; i++) begin
      send(vecs[i].data, mk_frame(vecs[i].data, vecs[i].par), vecs[i].exp_done, vecs[i].exp_err);
      dev_run(vecs[i].nack);
      repeat (3) @(negedge clk);
      check("idle_after", {31'd0, tx_stall}, 32'd0);
    end

    // Back-to-back with tx_valid held: second INHIBIT follows tx_done by one cycle.
    tx_valid = 1'b1;
    tx_data  = 8'hF4;
    push_exp(mk_frame(8'hF4, 1'b0), 1'b1, 1'b0);
    @(negedge clk);
    tx_data = 8'hED;
    push_exp(mk_frame(8'hED, 1'b1), 1'b1, 1'b0);
    dev_run(1'b0);
    tx_valid = 1'b0;
    check("b2b_inhibit_gap", inh_gap, 1);
    dev_run(1'b0);
    repeat (3) @(negedge clk);

    // Device never clocks: timeout error after TO cycles in XFER.
    d0 = done_cnt;
    e0 = err_cnt;
    send(8'h3C, mk_frame(8'h3C, 1'b1), 1'b0, 1'b1);
    junk = sb_q.pop_front();
    wait_xfer(ok);
    n = 0;
    while (!tx_err && (n < TO + 100)) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("timeout_latency", err_cyc - xfer_cyc, TO);
    check("timeout_lines", {30'd0, err_lines}, 32'd0);
    check("timeout_stall", {31'd0, tx_stall}, 32'd0);
    check("timeout_err_pulses", err_cnt - e0, 1);
    check("timeout_done_pulses", done_cnt - d0, 0);
    repeat (3) @(negedge clk);

    // Reset asserted at edge 5 of XFER drops both enables without a clock.
    send(8'hF4, mk_frame(8'hF4, 1'b0), 1'b1, 1'b0);
    junk = sb_q.pop_front();
    wait_xfer(ok);
    d0 = done_cnt;
    e0 = err_cnt;
    for (int i = 1; i <= 4; i++) dev_edge(b);
    dev_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    check("pre_reset_de", {30'd0, ce, de}, 32'b01);
    @(posedge clk);
    #2;
    rst_b = 1'b0;
    #1;
    check("async_reset_lines", {28'd0, ce, de, ps2_clk_out, ps2_dat_out}, 32'b0011);
    repeat (3) @(negedge clk);
    check("reset_no_done", done_cnt - d0, 0);
    check("reset_no_err", err_cnt - e0, 0);
    check("reset_stall", {31'd0, tx_stall}, 32'd0);
    dev_clk = 1'b1;
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    send(8'hF4, mk_frame(8'hF4, 1'b0), 1'b1, 1'b0);
    dev_run(1'b0);
    repeat (3) @(negedge clk);

    check("done_err_overlap", overlap, 0);
    check("scoreboard_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
